// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline: opcodes, ALU encodings,
// instruction field positions and the decoded control bundle.
package cpu_pkg;

    localparam int unsigned XLEN = 16;

    // Opcodes (instruction bits [15:12]); 1000-1111 are illegal
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_BEQZ = 4'h5;
    localparam logic [3:0] OP_J    = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;

    // Field bit positions (LSB of each field)
    localparam int unsigned OP_LSB    = 12;
    localparam int unsigned RD_LSB    = 9;
    localparam int unsigned RS_LSB    = 6;
    localparam int unsigned RT_LSB    = 3;
    localparam int unsigned FUNCT_LSB = 0;

    // R-type funct doubles as the ALU operation code
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    // All-zero value is a NOP bubble
    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    jump;
        logic    halt;
        logic    illegal;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic logic [XLEN-1:0] sext6(input logic [5:0] v);
        return {{(XLEN-6){v[5]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file: NREGS x 16, two combinational reads, one write per clock.
// r0 reads as zero and ignores writes; a same-cycle writeback is forwarded to the reads.
module decode_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_en;

    assign w_wr_en = i_we && (i_waddr != '0);

    // Storage: asynchronous clear, writes to r0 dropped
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read ports with write-through bypass
    always_comb begin
        o_rdata1 = '0;
        o_rdata2 = '0;
        if (i_raddr1 != '0) begin
            o_rdata1 = (w_wr_en && i_waddr == i_raddr1) ? i_wdata : r_regs[i_raddr1];
        end
        if (i_raddr2 != '0) begin
            o_rdata2 = (w_wr_en && i_waddr == i_raddr2) ? i_wdata : r_regs[i_raddr2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction decoder, register-file read, load-use hazard detection
// and the decode/execute pipeline register.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int unsigned NREGS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Instruct,
    input  logic [15:0] NextPCIn,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        WBWrite,
    input  logic [2:0]  WBReg,
    input  logic [15:0] WBData,
    output logic        LoadUseStall,
    output logic [15:0] NextPCOut,
    output logic [15:0] ReadData1,
    output logic [15:0] ReadData2,
    output logic [15:0] Imm,
    output logic [2:0]  DestReg,
    output logic [2:0]  ALUOp,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        Jump,
    output logic        HaltOut,
    output logic        Illegal
);

    logic [3:0]  w_op;
    logic [2:0]  w_rd, w_rs, w_rt, w_funct;
    logic [2:0]  w_p2_spec;
    logic        w_uses_rs, w_uses_p2;
    logic [2:0]  w_dest;
    logic [15:0] w_imm;
    ctrl_t       w_ctrl;
    logic [15:0] w_rdata1, w_rdata2;
    logic        w_lus;

    logic [15:0] r_pc, r_rd1, r_rd2, r_imm;
    logic [2:0]  r_dest;
    ctrl_t       r_ctrl;

    assign w_op    = Instruct[OP_LSB +: 4];
    assign w_rd    = Instruct[RD_LSB +: 3];
    assign w_rs    = Instruct[RS_LSB +: 3];
    assign w_rt    = Instruct[RT_LSB +: 3];
    assign w_funct = Instruct[FUNCT_LSB +: 3];

    // Stores read rd on the second port; everything else uses rt
    assign w_p2_spec = (w_op == OP_ST) ? w_rd : w_rt;

    decode_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_p2_spec),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (WBWrite),
        .i_waddr  (WBReg),
        .i_wdata  (WBData)
    );

    // Decoder: control bundle, immediate, destination and which operands are really read
    always_comb begin
        w_ctrl    = '0;
        w_imm     = '0;
        w_uses_rs = 1'b0;
        w_uses_p2 = 1'b0;
        w_dest    = w_rd;
        unique case (w_op)
            OP_NOP: ;
            OP_ALU: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = alu_op_e'(w_funct);
                w_uses_rs        = 1'b1;
                w_uses_p2        = 1'b1;
            end
            OP_ADDI: begin
                w_ctrl.reg_write = 1'b1;
                w_imm            = sext6(Instruct[5:0]);
                w_uses_rs        = 1'b1;
            end
            OP_LD: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.mem_read  = 1'b1;
                w_imm            = sext6(Instruct[5:0]);
                w_uses_rs        = 1'b1;
            end
            OP_ST: begin
                w_ctrl.mem_write = 1'b1;
                w_imm            = sext6(Instruct[5:0]);
                w_uses_rs        = 1'b1;
                w_uses_p2        = 1'b1;
            end
            OP_BEQZ: begin
                w_ctrl.branch = 1'b1;
                w_imm         = sext6(Instruct[5:0]);
                w_uses_rs     = 1'b1;
            end
            OP_J: begin
                w_ctrl.jump = 1'b1;
                w_imm       = sext12(Instruct[11:0]);
            end
            OP_HALT: w_ctrl.halt = 1'b1;
            default: w_ctrl.illegal = 1'b1;
        endcase
        if (!w_ctrl.reg_write) begin
            w_dest = '0;
        end
    end

    // Load-use hazard: the load in execute targets a register this instruction reads
    always_comb begin
        w_lus = 1'b0;
        if (r_ctrl.mem_read && r_dest != '0 && !Flush) begin
            w_lus = (w_uses_rs && w_rs == r_dest) || (w_uses_p2 && w_p2_spec == r_dest);
        end
    end

    assign LoadUseStall = w_lus;

    // Decode/execute register: reset/flush bubble, stall hold, hazard bubble, else load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc   <= '0;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_imm  <= '0;
            r_dest <= '0;
            r_ctrl <= '0;
        end else if (Flush || (w_lus && !Stall)) begin
            r_pc   <= '0;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_imm  <= '0;
            r_dest <= '0;
            r_ctrl <= '0;
        end else if (!Stall) begin
            r_pc   <= NextPCIn;
            r_rd1  <= w_rdata1;
            r_rd2  <= w_rdata2;
            r_imm  <= w_imm;
            r_dest <= w_dest;
            r_ctrl <= w_ctrl;
        end
    end

    assign NextPCOut = r_pc;
    assign ReadData1 = r_rd1;
    assign ReadData2 = r_rd2;
    assign Imm       = r_imm;
    assign DestReg   = r_dest;
    assign ALUOp     = r_ctrl.alu_op;
    assign RegWrite  = r_ctrl.reg_write;
    assign MemRead   = r_ctrl.mem_read;
    assign MemWrite  = r_ctrl.mem_write;
    assign Branch    = r_ctrl.branch;
    assign Jump      = r_ctrl.jump;
    assign HaltOut   = r_ctrl.halt;
    assign Illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Instruct = '0;
    logic [15:0] NextPCIn = '0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        WBWrite = 1'b0;
    logic [2:0]  WBReg = '0;
    logic [15:0] WBData = '0;
    logic        LoadUseStall;
    logic [15:0] NextPCOut, ReadData1, ReadData2, Imm;
    logic [2:0]  DestReg, ALUOp;
    logic        RegWrite, MemRead, MemWrite, Branch, Jump, HaltOut, Illegal;

    decode_stage #(.NREGS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .Instruct     (Instruct),
        .NextPCIn     (NextPCIn),
        .Stall        (Stall),
        .Flush        (Flush),
        .WBWrite      (WBWrite),
        .WBReg        (WBReg),
        .WBData       (WBData),
        .LoadUseStall (LoadUseStall),
        .NextPCOut    (NextPCOut),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .Imm          (Imm),
        .DestReg      (DestReg),
        .ALUOp        (ALUOp),
        .RegWrite     (RegWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Branch       (Branch),
        .Jump         (Jump),
        .HaltOut      (HaltOut),
        .Illegal      (Illegal)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0] pc, rd1, rd2, imm;
        logic [2:0]  dest, alu;
        logic        rw, mr, mw, br, j, h, ill;
        logic        c1, c2, ci;  // which data fields carry meaning
    } exp_t;

    logic [15:0] m_rf [8];
    exp_t        m_out;

    initial begin
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_out = '0;
    end

    function automatic exp_t bubble();
        exp_t e = '0;
        e.c1 = 1'b1; e.c2 = 1'b1; e.ci = 1'b1;
        return e;
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] r);
        if (r == 0) return 16'h0;
        if (WBWrite && WBReg == r) return WBData;
        return m_rf[r];
    endfunction

    function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
        logic [15:0] m = 16'hFFFF << bits;
        return v[bits-1] ? (v | m) : (v & ~m);
    endfunction

    function automatic exp_t m_decode(input logic [15:0] ins, input logic [15:0] pc);
        exp_t e = '0;
        int op = int'(ins[15:12]);
        logic [2:0] rd = ins[11:9], rs = ins[8:6], rt = ins[5:3];
        e.pc = pc;
        case (op)
            1: begin e.rw = 1; e.alu = ins[2:0]; e.rd1 = m_read(rs); e.rd2 = m_read(rt);
                     e.c1 = 1; e.c2 = 1; end
            2: begin e.rw = 1; e.rd1 = m_read(rs); e.c1 = 1; e.imm = sx(ins, 6); e.ci = 1; end
            3: begin e.rw = 1; e.mr = 1; e.rd1 = m_read(rs); e.c1 = 1; e.imm = sx(ins, 6);
                     e.ci = 1; end
            4: begin e.mw = 1; e.rd1 = m_read(rs); e.rd2 = m_read(rd); e.c1 = 1; e.c2 = 1;
                     e.imm = sx(ins, 6); e.ci = 1; end
            5: begin e.br = 1; e.rd1 = m_read(rs); e.c1 = 1; e.imm = sx(ins, 6); e.ci = 1; end
            6: begin e.j = 1; e.imm = sx(ins, 12); e.ci = 1; end
            7: e.h = 1;
            0: ;
            default: e.ill = 1;
        endcase
        e.dest = e.rw ? rd : 3'd0;
        return e;
    endfunction

    function automatic logic m_lus();
        int op = int'(Instruct[15:12]);
        logic [2:0] rd = Instruct[11:9], rs = Instruct[8:6], rt = Instruct[5:3];
        logic hit = 0;
        if (!m_out.mr || m_out.dest == 0 || Flush) return 1'b0;
        if (op inside {1, 2, 3, 4, 5} && rs == m_out.dest) hit = 1;
        if (op == 1 && rt == m_out.dest) hit = 1;
        if (op == 4 && rd == m_out.dest) hit = 1;
        return hit;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out = '0;
            for (int i = 0; i < 8; i++) m_rf[i] = '0;
        end else begin
            if (Flush) m_out = bubble();
            else if (Stall) m_out = m_out;
            else if (m_lus()) m_out = bubble();
            else m_out = m_decode(Instruct, NextPCIn);
            if (WBWrite && WBReg != 0) m_rf[WBReg] = WBData;
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("LoadUseStall", LoadUseStall, m_lus());
            chk("NextPCOut", NextPCOut, m_out.pc);
            if (m_out.c1) chk("ReadData1", ReadData1, m_out.rd1);
            if (m_out.c2) chk("ReadData2", ReadData2, m_out.rd2);
            if (m_out.ci) chk("Imm", Imm, m_out.imm);
            chk("DestReg", DestReg, m_out.dest);
            chk("ALUOp", ALUOp, m_out.alu);
            chk("RegWrite", RegWrite, m_out.rw);
            chk("MemRead", MemRead, m_out.mr);
            chk("MemWrite", MemWrite, m_out.mw);
            chk("Branch", Branch, m_out.br);
            chk("Jump", Jump, m_out.j);
            chk("HaltOut", HaltOut, m_out.h);
            chk("Illegal", Illegal, m_out.ill);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic        lus_s;
    logic [15:0] pc_ctr = 16'h0100;

    function automatic logic [15:0] mk_r(input int rd, rs, rt, fn);
        return {4'h1, 3'(rd), 3'(rs), 3'(rt), 3'(fn)};
    endfunction

    function automatic logic [15:0] mk_i(input int op, rd, rs, input logic [5:0] imm);
        return {4'(op), 3'(rd), 3'(rs), imm};
    endfunction

    function automatic logic [15:0] mk_j(input logic [11:0] imm);
        return {4'h6, imm};
    endfunction

    // Present one cycle of inputs, sample LoadUseStall mid-cycle, return just after the edge
    task automatic cyc(input logic [15:0] ins, input logic st, fl, wbw,
                       input logic [2:0] wbr, input logic [15:0] wbd);
        Instruct = ins; NextPCIn = pc_ctr; Stall = st; Flush = fl;
        WBWrite = wbw; WBReg = wbr; WBData = wbd;
        pc_ctr = pc_ctr + 16'd1;
        @(negedge clk);
        lus_s = LoadUseStall;
        @(posedge clk);
        #2;
    endtask

    task automatic cyc0(input logic [15:0] ins);
        cyc(ins, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Writeback bypass into a same-cycle read
        cyc(mk_r(1, 3, 0, 0), 1'b0, 1'b0, 1'b1, 3'd3, 16'hBEEF);
        chk("bypass ReadData1", ReadData1, 16'hBEEF);
        chk("bypass RegWrite", RegWrite, 1'b1);
        chk("bypass DestReg", DestReg, 3'd1);
        chk("bypass NextPCOut", NextPCOut, 16'h0100);

        // Write to r0 is ignored
        cyc(16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 16'h1234);
        cyc0(mk_r(5, 0, 0, 3'd4));
        chk("r0 ReadData1", ReadData1, 16'h0000);
        chk("r0 ReadData2", ReadData2, 16'h0000);
        chk("xor ALUOp", ALUOp, 3'd4);

        // Load-use via rs
        cyc0(mk_i(3, 2, 1, 6'd0));
        chk("ld MemRead", MemRead, 1'b1);
        chk("ld DestReg", DestReg, 3'd2);
        cyc0(mk_r(4, 2, 5, 0));
        chk("lu stall", lus_s, 1'b1);
        chk("lu bubble RegWrite", RegWrite, 1'b0);
        chk("lu bubble MemRead", MemRead, 1'b0);
        cyc0(mk_r(4, 2, 5, 0));
        chk("lu stall cleared", lus_s, 1'b0);
        chk("lu add RegWrite", RegWrite, 1'b1);
        chk("lu add DestReg", DestReg, 3'd4);

        // Load-use via the store's rd read
        cyc0(mk_i(3, 2, 1, 6'd0));
        cyc0(mk_i(4, 2, 1, 6'd0));
        chk("st stall", lus_s, 1'b1);
        cyc0(mk_i(4, 2, 1, 6'd0));
        chk("st MemWrite", MemWrite, 1'b1);
        chk("st DestReg", DestReg, 3'd0);

        // No false stalls
        cyc0(mk_i(3, 2, 1, 6'd0));
        cyc0(mk_j(12'h010));
        chk("j no stall", lus_s, 1'b0);
        chk("j Imm", Imm, 16'h0010);
        chk("j Jump", Jump, 1'b1);
        cyc0(mk_i(3, 2, 1, 6'd0));
        cyc0(mk_i(2, 2, 3, 6'd5));
        chk("addi no stall", lus_s, 1'b0);
        chk("addi Imm", Imm, 16'h0005);
        cyc0(mk_i(3, 0, 1, 6'd0));
        cyc0(mk_r(1, 0, 0, 0));
        chk("ld r0 no stall", lus_s, 1'b0);

        // Flush beats Stall
        cyc(mk_i(2, 1, 1, 6'h3F), 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
        chk("flush RegWrite", RegWrite, 1'b0);
        chk("flush DestReg", DestReg, 3'd0);
        chk("flush Imm", Imm, 16'h0000);

        // Stall holds contents
        cyc0(mk_i(2, 6, 0, 6'd7));
        for (int k = 0; k < 3; k++) begin
            cyc(16'h7000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
            chk("hold DestReg", DestReg, 3'd6);
            chk("hold Imm", Imm, 16'h0007);
            chk("hold HaltOut", HaltOut, 1'b0);
        end

        // Immediate decode and illegal opcode
        cyc0(mk_i(2, 1, 1, 6'b100000));
        chk("imm6 sext", Imm, 16'hFFE0);
        cyc0(mk_j(12'h801));
        chk("imm12 sext", Imm, 16'hF801);
        cyc0(16'hA123);
        chk("illegal", Illegal, 1'b1);
        chk("illegal RegWrite", RegWrite, 1'b0);
        chk("illegal Jump", Jump, 1'b0);
        chk("illegal DestReg", DestReg, 3'd0);

        // Asynchronous reset mid-operation, with a live hazard pending
        cyc0(mk_i(3, 2, 1, 6'd0));
        Instruct = mk_r(4, 2, 5, 0);
        #1 chk("pre-reset stall", LoadUseStall, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst LoadUseStall", LoadUseStall, 1'b0);
        chk("rst MemRead", MemRead, 1'b0);
        chk("rst DestReg", DestReg, 3'd0);
        chk("rst NextPCOut", NextPCOut, 16'h0000);
        chk("rst RegWrite", RegWrite, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int r = 1; r < 8; r++) begin
            cyc0(mk_i(4, r, r, 6'd0));
            chk("post-rst rs read", ReadData1, 16'h0000);
            chk("post-rst rd read", ReadData2, 16'h0000);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            case ($urandom_range(0, 7))
                0, 1: ins[15:12] = 4'h3;
                2: ins[15:12] = 4'($urandom_range(8, 15));
                default: ins[15:12] = 4'($urandom_range(0, 7));
            endcase
            cyc(ins, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                1'($urandom), 3'($urandom), 16'($urandom));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
